alu_instr_sequencer: RTL and testbench

//  Upstream feeder for the 8-bit accumulator ALU. It buffers a short program of
//  {opcode, A, B} instructions written by a host and issues them to the ALU one
//  at a time. Each instruction is held stable for ALU_LAT cycles. The ALU result
//  is then captured and presented as a one-cycle result strobe with its index.

---
 rtl/alu_instr_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Instruction buffer and issue sequencer feeding the 8-bit accumulator ALU.
// Buffers {opcode, A, B} entries, issues them one at a time, and returns each result with its index.
module alu_instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_opcode,
  input  logic [7:0]        wr_a,
  input  logic [7:0]        wr_b,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        alu_result,
  output logic [3:0]        opcode,
  output logic [7:0]        A,
  output logic [7:0]        B,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [7:0]        res_data,
  output logic [ADDR_W-1:0] res_index
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT);
  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] WCNT_SMP  = CNT_W'(ALU_LAT - 2);
  localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_fire, load_ops, sample;

  logic [3:0]        opcode_q, opcode_d;
  logic [7:0]        a_q, a_d, b_q, b_d;
  logic              full_q, full_d, busy_q, busy_d, done_q, done_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_index_q, res_index_d;

  logic [3:0]        mem_op [DEPTH];
  logic [7:0]        mem_a  [DEPTH];
  logic [7:0]        mem_b  [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
    end
  end

  // Buffer storage is deliberately not reset; count gates what is readable.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      mem_op[count_q[ADDR_W-1:0]] <= wr_opcode;
      mem_a[count_q[ADDR_W-1:0]]  <= wr_a;
      mem_b[count_q[ADDR_W-1:0]]  <= wr_b;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    count_d  = count_q;
    wr_fire  = 1'b0;
    load_ops = 1'b0;
    sample   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          count_d = '0;
        end else if (start && count_q != '0) begin
          idx_d    = '0;
          load_ops = 1'b1;
          state_d  = S_ISSUE;
        end else if (wr_en && count_q != DEPTH_C) begin
          wr_fire = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
        if (ALU_LAT == 1) sample = 1'b1;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // wcnt counts edges after the ISSUE cycle, so the sample edge is one before the last
        if (ALU_LAT >= 2 && wcnt_q == WCNT_SMP) sample = 1'b1;
        if (wcnt_q == WCNT_LAST) begin
          if ({1'b0, idx_q} == count_q - 1'b1) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            load_ops = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (clr) begin
          count_d = '0;
          state_d = S_IDLE;
        end else if (start) begin
          idx_d    = '0;
          load_ops = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opcode_d    = load_ops ? mem_op[idx_d] : opcode_q;
    a_d         = load_ops ? mem_a[idx_d]  : a_q;
    b_d         = load_ops ? mem_b[idx_d]  : b_q;
    res_valid_d = sample;
    res_data_d  = sample ? alu_result : res_data_q;
    res_index_d = sample ? idx_q : res_index_q;
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d      = (state_d == S_DONE);
    full_d      = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      full_q      <= full_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
    end
  end

  assign opcode    = opcode_q;
  assign A         = a_q;
  assign B         = b_q;
  assign full      = full_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_index = res_index_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer with a latency-accurate ALU stub.
// Expected results come from a program-level model; a monitor pops them on each res_valid.
module tb_alu_instr_sequencer;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int ALU_LAT = 2;

  logic              clk = 1'b0;
  logic              reset, wr_en, clr, start;
  logic [3:0]        wr_opcode;
  logic [7:0]        wr_a, wr_b, alu_result;
  logic [3:0]        opcode;
  logic [7:0]        A, B;
  logic              full, busy, done, res_valid;
  logic [ADDR_W:0]   count;
  logic [7:0]        res_data;
  logic [ADDR_W-1:0] res_index;

  alu_instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_opcode(wr_opcode), .wr_a(wr_a), .wr_b(wr_b),
    .clr(clr), .start(start), .alu_result(alu_result), .opcode(opcode), .A(A), .B(B),
    .full(full), .count(count), .busy(busy), .done(done), .res_valid(res_valid),
    .res_data(res_data), .res_index(res_index)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    return (op == 4'h0) ? 8'(a + b) : a;
  endfunction

  // ALU_LAT=2: one register stage, so the result is stable at the second edge after presentation
  always @(posedge clk) alu_result <= ref_alu(opcode, A, B);

  typedef struct { logic [3:0] op; logic [7:0] a; logic [7:0] b; } instr_t;
  typedef struct { logic [7:0] data; int idx; } res_t;
  instr_t prog[$];
  res_t   exp_q[$];
  int checks = 0, errors = 0;
  int res_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      res_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res: got data %0d index %0d expected no result", res_data, res_index);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_index", res_index, e.idx);
      end
    end
  end

  task automatic write_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    wr_en = 1'b1; wr_opcode = op; wr_a = a; wr_b = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (prog.size() < DEPTH) prog.push_back('{op: op, a: a, b: b});
    chk("count", count, prog.size());
    chk("full", full, (prog.size() == DEPTH) ? 1 : 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    prog.delete();
    chk("clr_count", count, 0);
    chk("clr_done", done, 0);
    chk("clr_busy", busy, 0);
  endtask

  task automatic run_prog(input bit poke);
    int n;
    foreach (prog[i]) exp_q.push_back('{data: ref_alu(prog[i].op, prog[i].a, prog[i].b), idx: i});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    if (poke) begin
      @(negedge clk);
      start = 1'b1; wr_en = 1'b1; wr_opcode = 4'h3; wr_a = 8'hAA; wr_b = 8'h55;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      chk("busy_write_count", count, prog.size());
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
    chk("done_busy", busy, 0);
    chk("results_left", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0;
    wr_opcode = '0; wr_a = '0; wr_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    reset = 1'b0;
    @(negedge clk);

    write_instr(4'h0, 8'h01, 8'h01);
    write_instr(4'h0, 8'h02, 8'h03);
    write_instr(4'h1, 8'h7F, 8'h00);
    run_prog(1'b0);

    // rerun from DONE, with a mid-run start and write that must be ignored
    run_prog(1'b1);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("done_write_count", count, 3);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    prog.delete();
    @(negedge clk);
    chk("clr_over_start_busy", busy, 0);
    chk("clr_over_start_count", count, 0);
    chk("clr_over_start_done", done, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("empty_start_busy", busy, 0);
    chk("empty_start_done", done, 0);

    for (int i = 0; i < 5; i++) write_instr(4'(i + 2), 8'(8'h10 * i + 1), 8'(i));
    chk("full_after5", full, 1);
    run_prog(1'b0);
    do_clr();

    write_instr(4'h0, 8'h11, 8'h22);
    write_instr(4'h0, 8'h33, 8'h44);
    write_instr(4'h5, 8'h66, 8'h77);
    foreach (prog[i]) exp_q.push_back('{data: ref_alu(prog[i].op, prog[i].a, prog[i].b), idx: i});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_res_seen", res_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    prog.delete();
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_opcode", opcode, 0);
    res_seen = 0;
    repeat (10) @(negedge clk);
    chk("no_res_after_reset", res_seen, 0);
    chk("idle_after_reset", busy | done, 0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++)
        write_instr(($urandom % 3 == 0) ? 4'($urandom) : 4'h0, 8'($urandom), 8'($urandom));
      run_prog(r[0]);
      if (r[1]) run_prog(1'b0);
      do_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
